// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: blank gap + dwell per digit, frame-synchronous load.
// Optional per-digit blinking is compiled in with `define DISP_BLINK_EN.
module display_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic                    load_ack,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_done
);

  localparam int unsigned DW      = 4 * NUM_DIGITS;
  localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {ST_BLANK, ST_ON} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]         active_q, active_d;
  logic [DW-1:0]         pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic                  frame_done_q, frame_done_d;
  logic                  load_ack_q, load_ack_d;
  logic [3:0]            bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] anode_n_q, anode_n_d;
  logic                  wrap_c;
  logic [NUM_DIGITS-1:0] blink_dark_c;

  // Scan FSM next state plus the frame-boundary load handshake
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + CNT_W'(1);
    active_d     = active_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    frame_done_d = 1'b0;
    load_ack_d   = 1'b0;
    wrap_c       = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      end
      ST_ON: begin
        if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d  = '0;
            wrap_c = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
    frame_done_d = wrap_c;
    if (wrap_c && pend_vld_q) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
      load_ack_d = 1'b1;
    end
    // A load on the boundary edge re-arms pending after the old value was applied
    if (load) begin
      pend_d     = digits_in;
      pend_vld_d = 1'b1;
    end
  end

  // Registered outputs are computed from next state so they line up with the FSM registers
  always_comb begin
    bcd_d     = 4'd0;
    anode_n_d = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        bcd_d = active_d[4*i +: 4];
        if (state_d == ST_ON) begin
          anode_n_d[i] = blink_dark_c[i] ||
                         (lz_blank && (i == NUM_DIGITS - 1) && (active_d[DW-1 -: 4] == 4'd0));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      active_q     <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
      load_ack_q   <= 1'b0;
      bcd_q        <= 4'd0;
      anode_n_q    <= '1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      frame_done_q <= frame_done_d;
      load_ack_q   <= load_ack_d;
      bcd_q        <= bcd_d;
      anode_n_q    <= anode_n_d;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int unsigned BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BF_W-1:0] bcnt_q, bcnt_d;
  logic            phase_q, phase_d;

  // Blink phase flips every BLINK_FRAMES frame boundaries
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (wrap_c) begin
      if (bcnt_q == BF_W'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BF_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_dark_c = phase_d ? blink_mask : '0;
`else
  logic unused_blink;
  assign unused_blink = (^blink_mask) ^ (BLINK_FRAMES == 0);
  assign blink_dark_c = '0;
`endif

  assign load_ack   = load_ack_q;
  assign bcd_out    = bcd_q;
  assign anode_n    = anode_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: per-frame vector table feeding a per-cycle scoreboard.
module tb_display_scan_ctrl;
  localparam int unsigned ND    = 4;
  localparam int unsigned DWELL = 4;
  localparam int unsigned BLANK = 2;
  localparam int unsigned FRAME = ND * (DWELL + BLANK);

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] digits_in;
  logic        lz_blank;
  logic [3:0]  blink_mask;
  logic        load_ack;
  logic [3:0]  bcd_out;
  logic [3:0]  anode_n;
  logic        frame_done;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANK),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .digits_in (digits_in),
    .lz_blank  (lz_blank),
    .blink_mask(blink_mask),
    .load_ack  (load_ack),
    .bcd_out   (bcd_out),
    .anode_n   (anode_n),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [3:0] anode;
    logic [3:0] bcd;
    logic       fd;
    logic       ack;
  } exp_t;

  typedef struct {
    logic [15:0] shown;
    bit          lz;
    bit          fd;
    bit          ack;
    logic [15:0] ld1;
    int          ld1_cyc;
    logic [15:0] ld2;
    int          ld2_cyc;
  } frame_vec_t;

  exp_t       sb_q[$];
  frame_vec_t vecs[9];
  int         checks = 0;
  int         errors = 0;

  // Expected per-cycle outputs for one frame showing 'shown'
  task automatic push_frame(input logic [15:0] shown, input bit lz, input bit fd, input bit ack,
                            input logic [3:0] dark);
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < int'(BLANK + DWELL); c++) begin
        e.bcd   = shown[4*d +: 4];
        e.fd    = fd && (d == 0) && (c == 0);
        e.ack   = ack && (d == 0) && (c == 0);
        e.anode = 4'hF;
        if (c >= int'(BLANK) && !dark[d] && !(lz && d == 3 && shown[15:12] == 4'h0))
          e.anode[d] = 1'b0;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic check_cycle(input string tag);
    exp_t e;
    exp_t got;
    got = {anode_n, bcd_out, frame_done, load_ack};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty, got %b/%h/%b/%b", tag, got.anode, got.bcd, got.fd, got.ack);
      return;
    end
    e = sb_q.pop_front();
    if (got !== e) begin
      errors++;
      $display("FAIL %s anode/bcd/fd/ack got %b/%h/%b/%b want %b/%h/%b/%b", tag,
               got.anode, got.bcd, got.fd, got.ack, e.anode, e.bcd, e.fd, e.ack);
    end
  endtask

  task automatic check_reset(input string tag);
    checks++;
    if ({anode_n, bcd_out, frame_done, load_ack} !== {4'hF, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s anode/bcd/fd/ack got %b/%h/%b/%b want 1111/0/0/0", tag,
               anode_n, bcd_out, frame_done, load_ack);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic run_frame(input frame_vec_t v, input logic [3:0] dark, input string name);
    lz_blank = v.lz;
    push_frame(v.shown, v.lz, v.fd, v.ack, dark);
    for (int c = 0; c < int'(FRAME); c++) begin
      check_cycle($sformatf("%s_c%0d", name, c));
      if (c == v.ld1_cyc) begin load = 1'b1; digits_in = v.ld1; end
      if (c == v.ld2_cyc) begin load = 1'b1; digits_in = v.ld2; end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] dark;
    reset = 1'b1; load = 1'b0; digits_in = '0; lz_blank = 1'b0; blink_mask = 4'b0000;

    //               shown     lz    fd    ack   ld1       cyc ld2       cyc
    vecs[0] = '{16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234,  5, 16'h0000, -1};
    vecs[1] = '{16'h1234, 1'b0, 1'b1, 1'b1, 16'h0000, -1, 16'h0000, -1};
    vecs[2] = '{16'h1234, 1'b0, 1'b1, 1'b0, 16'h0905, 10, 16'h0000, -1};
    vecs[3] = '{16'h0905, 1'b0, 1'b1, 1'b1, 16'h1111,  3, 16'h2222, 15};
    vecs[4] = '{16'h2222, 1'b0, 1'b1, 1'b1, 16'h0930,  7, 16'h0000, -1};
    vecs[5] = '{16'h0930, 1'b0, 1'b1, 1'b1, 16'h0000, -1, 16'h0000, -1};
    vecs[6] = '{16'h0930, 1'b1, 1'b1, 1'b0, 16'h0012,  8, 16'h0000, -1};
    vecs[7] = '{16'h0012, 1'b1, 1'b1, 1'b1, 16'hF0AB, 20, 16'h0000, -1};
    vecs[8] = '{16'hF0AB, 1'b1, 1'b1, 1'b1, 16'h0000, -1, 16'h0000, -1};

    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_state");
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_frame(vecs[i], 4'b0000, $sformatf("frame%0d", i));

    // Reset during digit 2's ON slot drops the frame and the pending load
    lz_blank = 1'b1;
    push_frame(16'hF0AB, 1'b1, 1'b1, 1'b0, 4'b0000);
    for (int c = 0; c < 16; c++) begin
      check_cycle($sformatf("midrst_c%0d", c));
      if (c == 2) begin load = 1'b1; digits_in = 16'h5555; end
      if (c == 15) reset = 1'b1;
      tick();
    end
    sb_q.delete();
    check_reset("midrst_after");
    reset = 1'b0;
    run_frame('{16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, -1, 16'h0000, -1}, 4'b0000, "postrst0");
    run_frame('{16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, -1, 16'h0000, -1}, 4'b0000, "postrst1");

    // Blink over six frames; without the feature the mask must have no effect
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    blink_mask = 4'b0011;
    for (int f = 0; f < 6; f++) begin
      dark = 4'b0000;
`ifdef DISP_BLINK_EN
      if (f == 2 || f == 3) dark = 4'b0011;
`endif
      run_frame('{(f == 0) ? 16'h0000 : 16'h4321, 1'b0, f != 0, f == 1,
                  16'h4321, (f == 0) ? 4 : -1, 16'h0000, -1},
                dark, $sformatf("blink%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
